// File: rtl/mesh_term_endpoint.sv
// Terminal-side endpoint for one mesh router port: buffers outgoing packets for the router
// and drains the router's output into a local receive FIFO, with traffic counters and error flags.
module mesh_term_endpoint #(
   parameter int PCKG_SZ  = 40,
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8,
   parameter int ID_ROW   = 0,
   parameter int ID_COL   = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tx_push,
   input  logic [PCKG_SZ-1:0] tx_data,
   output logic               tx_full,
   output logic               pndng_i_in,
   output logic [PCKG_SZ-1:0] data_out_i_in,
   input  logic               popin,
   input  logic               pndng,
   input  logic [PCKG_SZ-1:0] data_out,
   output logic               pop,
   output logic               rx_valid,
   output logic [PCKG_SZ-1:0] rx_data,
   input  logic               rx_rd,
   output logic [15:0]        tx_cnt,
   output logic [15:0]        rx_cnt,
   output logic               err_ovf,
   output logic               err_udf,
   output logic               err_misroute
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int TX_CW = TX_AW + 1;
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int RX_CW = RX_AW + 1;
   localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
   localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
   localparam logic [3:0] MY_ROW = 4'(ID_ROW);
   localparam logic [3:0] MY_COL = 4'(ID_COL);

   logic [PCKG_SZ-1:0] tx_mem [TX_DEPTH];
   logic [TX_AW-1:0]   tx_wr_ptr, tx_rd_ptr;
   logic [TX_CW-1:0]   tx_count;
   logic               tx_do_push, tx_do_pop;

   logic [PCKG_SZ-1:0] rx_mem [RX_DEPTH];
   logic [RX_AW-1:0]   rx_wr_ptr, rx_rd_ptr;
   logic [RX_CW-1:0]   rx_count;
   logic               rx_full, rx_do_rd, misrouted;

   // ---------------- TX FIFO (user -> router) ----------------
   assign pndng_i_in    = (tx_count != '0);
   assign tx_full       = (tx_count == TX_FULL_CNT);
   assign tx_do_pop     = popin & pndng_i_in;
   // A full FIFO still accepts a push when the router retires the head in the same cycle.
   assign tx_do_push    = tx_push & (~tx_full | tx_do_pop);
   assign data_out_i_in = pndng_i_in ? tx_mem[tx_rd_ptr] : '0;

   // NOTE: storage arrays carry no reset; the occupancy count alone defines what is valid.
   always_ff @(posedge clk) begin
      if (tx_do_push) tx_mem[tx_wr_ptr] <= tx_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         tx_cnt    <= '0;
         err_ovf   <= 1'b0;
         err_udf   <= 1'b0;
      end else begin
         if (tx_do_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
         if (tx_do_pop) begin
            tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            tx_cnt    <= tx_cnt + 16'd1;
         end
         tx_count <= tx_count + TX_CW'(tx_do_push) - TX_CW'(tx_do_pop);
         if (tx_push & tx_full & ~popin) err_ovf <= 1'b1;
         if (popin & ~pndng_i_in)        err_udf <= 1'b1;
      end
   end

   // ---------------- RX FIFO (router -> user) ----------------
   assign rx_valid  = (rx_count != '0);
   assign rx_full   = (rx_count == RX_FULL_CNT);
   assign rx_do_rd  = rx_rd & rx_valid;
   // No full-bypass: a read in the same cycle frees space only from the next cycle on.
   assign pop       = pndng & ~rx_full & reset;
   assign rx_data   = rx_valid ? rx_mem[rx_rd_ptr] : '0;
   assign misrouted = (data_out[PCKG_SZ-9 -: 4] != MY_ROW) ||
                      (data_out[PCKG_SZ-13 -: 4] != MY_COL);

   always_ff @(posedge clk) begin
      if (pop) rx_mem[rx_wr_ptr] <= data_out;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wr_ptr    <= '0;
         rx_rd_ptr    <= '0;
         rx_count     <= '0;
         rx_cnt       <= '0;
         err_misroute <= 1'b0;
      end else begin
         if (pop) begin
            rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            rx_cnt    <= rx_cnt + 16'd1;
            if (misrouted) err_misroute <= 1'b1;
         end
         if (rx_do_rd) rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
         rx_count <= rx_count + RX_CW'(pop) - RX_CW'(rx_do_rd);
      end
   end

endmodule

// File: tb/tb_mesh_term_endpoint.sv
// Scoreboard bench for mesh_term_endpoint: a queue-based reference model predicts flags, counters
// and packet order; a separate monitor compares packets whenever a handshake completes.
module tb_mesh_term_endpoint;

   localparam int PCKG_SZ  = 40;
   localparam int TX_DEPTH = 8;
   localparam int RX_DEPTH = 8;
   localparam logic [3:0] MY_ROW = 4'd1;
   localparam logic [3:0] MY_COL = 4'd2;

   typedef logic [PCKG_SZ-1:0] pkt_t;

   logic        clk, reset;
   logic        tx_push, popin, pndng, rx_rd;
   pkt_t        tx_data, data_out;
   logic        tx_full, pndng_i_in, pop, rx_valid;
   pkt_t        data_out_i_in, rx_data;
   logic [15:0] tx_cnt, rx_cnt;
   logic        err_ovf, err_udf, err_misroute;

   mesh_term_endpoint #(
      .PCKG_SZ(PCKG_SZ), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH),
      .ID_ROW(int'(MY_ROW)), .ID_COL(int'(MY_COL))
   ) dut (
      .clk(clk), .reset(reset),
      .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full),
      .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
      .pndng(pndng), .data_out(data_out), .pop(pop),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
      .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
      .err_ovf(err_ovf), .err_udf(err_udf), .err_misroute(err_misroute)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: occupancies, counters, sticky flags, and expected packet streams.
   int          tx_occ, rx_occ;
   logic [15:0] m_tx_cnt, m_rx_cnt;
   bit          m_ovf, m_udf, m_mis;
   pkt_t        exp_tx_q[$];
   pkt_t        exp_rx_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic pkt_t rand_pkt(input bit good);
      pkt_t p;
      p = pkt_t'({$urandom, $urandom});
      if (good) begin
         p[PCKG_SZ-9 -: 4]  = MY_ROW;
         p[PCKG_SZ-13 -: 4] = MY_COL;
      end
      return p;
   endfunction

   function automatic pkt_t mk_dest(input logic [3:0] row, input logic [3:0] col);
      pkt_t p;
      p = rand_pkt(1'b0);
      p[PCKG_SZ-9 -: 4]  = row;
      p[PCKG_SZ-13 -: 4] = col;
      return p;
   endfunction

   task automatic check_status();
      check("pndng_i_in", pndng_i_in, tx_occ != 0);
      check("tx_full", tx_full, tx_occ == TX_DEPTH);
      check("rx_valid", rx_valid, rx_occ != 0);
      check("tx_cnt", tx_cnt, m_tx_cnt);
      check("rx_cnt", rx_cnt, m_rx_cnt);
      check("err_ovf", err_ovf, m_ovf);
      check("err_udf", err_udf, m_udf);
      check("err_misroute", err_misroute, m_mis);
      if (tx_occ == 0) check("tx_head_empty", data_out_i_in, '0);
      if (rx_occ == 0) check("rx_head_empty", rx_data, '0);
   endtask

   task automatic model_reset();
      tx_occ = 0; rx_occ = 0;
      m_tx_cnt = '0; m_rx_cnt = '0;
      m_ovf = 1'b0; m_udf = 1'b0; m_mis = 1'b0;
      exp_tx_q.delete();
      exp_rx_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      tx_push = 1'b0; popin = 1'b0; pndng = 1'b1; rx_rd = 1'b0;
      tx_data = '0; data_out = '0;
      model_reset();
      #1;
      check_status();
      check("pop_in_reset", pop, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      pndng = 1'b0;
   endtask

   // One cycle: check state left by the previous edge, predict the next edge, drive inputs.
   task automatic step(input bit t_push, input pkt_t t_data, input bit t_popin,
                       input bit r_pndng, input pkt_t r_data, input bit r_rd);
      bit pop_ok, push_ok, m_pop, rd_ok;
      @(negedge clk);
      check_status();
      pop_ok  = t_popin && (tx_occ > 0);
      push_ok = t_push && ((tx_occ < TX_DEPTH) || pop_ok);
      if (t_popin && tx_occ == 0) m_udf = 1'b1;
      if (t_push && tx_occ == TX_DEPTH && !t_popin) m_ovf = 1'b1;
      if (push_ok) exp_tx_q.push_back(t_data);
      if (pop_ok) m_tx_cnt++;
      tx_occ = tx_occ + int'(push_ok) - int'(pop_ok);
      m_pop = r_pndng && (rx_occ < RX_DEPTH);
      rd_ok = r_rd && (rx_occ > 0);
      if (m_pop) begin
         exp_rx_q.push_back(r_data);
         m_rx_cnt++;
         if (r_data[PCKG_SZ-9 -: 4] != MY_ROW || r_data[PCKG_SZ-13 -: 4] != MY_COL) m_mis = 1'b1;
      end
      rx_occ = rx_occ + int'(m_pop) - int'(rd_ok);
      tx_push = t_push; tx_data = t_data; popin = t_popin;
      pndng = r_pndng; data_out = r_data; rx_rd = r_rd;
      #1;
      check("pop", pop, m_pop);
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   // Monitor: compares packet heads whenever a handshake is about to complete.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset && popin && pndng_i_in) begin
            if (exp_tx_q.size() == 0) check("tx_pkt_unexpected", data_out_i_in, 'x);
            else check("tx_pkt", data_out_i_in, exp_tx_q.pop_front());
         end
         if (reset && rx_rd && rx_valid) begin
            if (exp_rx_q.size() == 0) check("rx_pkt_unexpected", rx_data, 'x);
            else check("rx_pkt", rx_data, exp_rx_q.pop_front());
         end
      end
   end

   initial begin
      reset = 1'b0;
      tx_push = 1'b0; popin = 1'b0; pndng = 1'b0; rx_rd = 1'b0;
      tx_data = '0; data_out = '0;
      model_reset();

      // Single packet through TX, then one router pop.
      do_reset();
      step(1'b1, 40'hA5_0000_0001, 1'b0, 1'b0, '0, 1'b0);
      check("tx_head_first", 64'(40'hA5_0000_0001), 64'(exp_tx_q[0]));
      step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      idle();

      // Overflow: nine pushes into eight slots, then drain and one underflow pop.
      for (int i = 0; i < 9; i++) step(1'b1, rand_pkt(1'b1), 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      idle();

      // Full TX with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < TX_DEPTH; i++) step(1'b1, rand_pkt(1'b1), 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, rand_pkt(1'b1), 1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < TX_DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      idle();

      // RX back-pressure: ten offers into eight slots, a read, then drain.
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, rand_pkt(1'b1), 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, rand_pkt(1'b1), 1'b1);
      step(1'b0, '0, 1'b0, 1'b1, rand_pkt(1'b1), 1'b0);
      for (int i = 0; i < RX_DEPTH + 1; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      idle();

      // Misroute: correct destination first, wrong destination second.
      do_reset();
      step(1'b0, '0, 1'b0, 1'b1, mk_dest(MY_ROW, MY_COL), 1'b0);
      idle();
      step(1'b0, '0, 1'b0, 1'b1, mk_dest(4'd3, 4'd0), 1'b0);
      idle();
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      idle();

      // Random traffic on both sides with a reset in the middle.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         step($urandom_range(0, 99) < 60, rand_pkt($urandom_range(0, 9) != 0),
              $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50,
              rand_pkt($urandom_range(0, 19) != 0), $urandom_range(0, 99) < 50);
      end
      idle();

      // tx_cnt wrap: 65536 router pops bring the counter back to zero.
      do_reset();
      step(1'b1, rand_pkt(1'b1), 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 65536; i++) step(1'b1, pkt_t'(i), 1'b1, 1'b0, '0, 1'b0);
      idle();
      check("tx_cnt_wrapped", tx_cnt, 16'h0000);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
